cordic_fsm_ctrl: RTL and testbench

CORDIC_FSM_CTRL -- requirements
Module: cordic_fsm_ctrl

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_fsm_ctrl_if.sv | 36 +++
 rtl/cordic_iter_cnt.sv | 42 ++++
 rtl/cordic_fsm_ctrl.sv | 120 ++++++++++++
 tb/tb_cordic_fsm_ctrl.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cordic_pkg.sv
// ============================================================================
// Module      : cordic_pkg
// Description : Shared state encoding and default index width for the CORDIC
//               iteration controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cordic_pkg;

    localparam int unsigned C_N_DEFAULT = 4;

    localparam logic [2:0] C_ST_IDLE      = 3'd0;
    localparam logic [2:0] C_ST_LOAD_INIT = 3'd1;
    localparam logic [2:0] C_ST_ITERATE   = 3'd2;
    localparam logic [2:0] C_ST_LOAD_RES  = 3'd3;
    localparam logic [2:0] C_ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = C_ST_IDLE,
        ST_LOAD_INIT = C_ST_LOAD_INIT,
        ST_ITERATE   = C_ST_ITERATE,
        ST_LOAD_RES  = C_ST_LOAD_RES,
        ST_DONE      = C_ST_DONE
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cordic_fsm_ctrl_if.sv
// ============================================================================
// Module      : cordic_fsm_ctrl_if
// Description : Start/acknowledge handshake and datapath control strobes
//               between the CORDIC controller and its user.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cordic_fsm_ctrl_if
    import cordic_pkg::*;
#(
    parameter int N = C_N_DEFAULT
);
    logic         beg_cordic;
    logic         ack_cordic;
    logic [N-1:0] iter_max;
    logic         load_init;
    logic         enab_iter;
    logic [N-1:0] iter_idx;
    logic         load_result;
    logic         ready_cordic;
    logic         busy;

    modport master (
        output beg_cordic, ack_cordic, iter_max,
        input  load_init, enab_iter, iter_idx, load_result, ready_cordic, busy
    );

    modport slave (
        input  beg_cordic, ack_cordic, iter_max,
        output load_init, enab_iter, iter_idx, load_result, ready_cordic, busy
    );

endinterface

`default_nettype wire

// File: rtl/cordic_iter_cnt.sv
// ============================================================================
// Module      : cordic_iter_cnt
// Description : Iteration index counter with synchronous clear, enable and a
//               terminal-count flag against the latched iteration limit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cordic_iter_cnt
    import cordic_pkg::*;
#(
    parameter int N = C_N_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_clr,
    input  wire logic         i_en,
    input  wire logic [N-1:0] i_lim,
    output logic      [N-1:0] o_cnt,
    output logic              o_tc
);

    logic [N-1:0] r_cnt;
    logic         w_tc;

    assign w_tc = (r_cnt == i_lim);

    // Holding at terminal count keeps a full 2^N-iteration run from wrapping.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

`default_nettype wire

// File: rtl/cordic_fsm_ctrl.sv
// ============================================================================
// Module      : cordic_fsm_ctrl
// Description : Moore controller sequencing operand load, iter_max+1 CORDIC
//               micro-rotations, result capture and the ready/ack handshake.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cordic_fsm_ctrl
    import cordic_pkg::*;
#(
    parameter int N = C_N_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        reset,
    cordic_fsm_ctrl_if.slave bus
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_iter_lim;
    logic [N-1:0] w_cnt;
    logic         w_tc;
    logic         w_cnt_clr;
    logic         w_cnt_en;
    logic         w_load_init;
    logic         w_enab_iter;
    logic [N-1:0] w_iter_idx;
    logic         w_load_result;
    logic         w_ready;
    logic         w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The limit is captured only on an accepted start so later iter_max
    // changes cannot disturb a running operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iter_lim <= '0;
        end else if (r_state == ST_IDLE && bus.beg_cordic) begin
            r_iter_lim <= bus.iter_max;
        end
    end

    assign w_cnt_clr = (r_state == ST_LOAD_INIT);
    assign w_cnt_en  = (r_state == ST_ITERATE);

    cordic_iter_cnt #(
        .N (N)
    ) u_iter_cnt (
        .clk   (clk),
        .rst   (reset),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .i_lim (r_iter_lim),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_load_init   = 1'b0;
        w_enab_iter   = 1'b0;
        w_iter_idx    = '0;
        w_load_result = 1'b0;
        w_ready       = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.beg_cordic) begin
                    w_state_nxt = ST_LOAD_INIT;
                end
            end
            ST_LOAD_INIT: begin
                w_load_init = 1'b1;
                w_busy      = 1'b1;
                w_state_nxt = ST_ITERATE;
            end
            ST_ITERATE: begin
                w_enab_iter = 1'b1;
                w_iter_idx  = w_cnt;
                w_busy      = 1'b1;
                if (w_tc) begin
                    w_state_nxt = ST_LOAD_RES;
                end
            end
            ST_LOAD_RES: begin
                w_load_result = 1'b1;
                w_busy        = 1'b1;
                w_state_nxt   = ST_DONE;
            end
            ST_DONE: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (bus.ack_cordic) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.load_init    = w_load_init;
    assign bus.enab_iter    = w_enab_iter;
    assign bus.iter_idx     = w_iter_idx;
    assign bus.load_result  = w_load_result;
    assign bus.ready_cordic = w_ready;
    assign bus.busy         = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_cordic_fsm_ctrl.sv
// ============================================================================
// Module      : tb_cordic_fsm_ctrl
// Description : Scoreboard bench: a cycle-count reference model predicts the
//               controller outputs; a negedge monitor compares them.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cordic_fsm_ctrl;

    localparam int N = 4;

    typedef struct packed {
        logic         li;
        logic         en;
        logic [N-1:0] idx;
        logic         lr;
        logic         rdy;
        logic         bsy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;
    exp_t q[$];

    // Reference model: active flag, cycles since acceptance, latched limit.
    bit m_act = 1'b0;
    int m_t   = 0;
    int m_lim = 0;

    cordic_fsm_ctrl_if #(.N(N)) ifc ();

    cordic_fsm_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic bit model_done();
        return m_act && (m_t >= m_lim + 4);
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (m_act) begin
            e.bsy = 1'b1;
            if (m_t == 1) begin
                e.li = 1'b1;
            end else if (m_t >= 2 && m_t <= m_lim + 2) begin
                e.en  = 1'b1;
                e.idx = N'(m_t - 2);
            end else if (m_t == m_lim + 3) begin
                e.lr = 1'b1;
            end else begin
                e.rdy = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic cyc(input logic b, input logic a, input logic r, input logic [N-1:0] m);
        ifc.beg_cordic = b;
        ifc.ack_cordic = a;
        ifc.iter_max   = m;
        reset          = r;
        @(posedge clk);
        if (r) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (b) begin
                m_act = 1'b1;
                m_t   = 1;
                m_lim = int'(m);
            end
        end else if (model_done()) begin
            if (a) m_act = 1'b0;
        end else begin
            m_t++;
        end
        q.push_back(model_out());
        #1;
    endtask

    task automatic run_to_done(input logic [N-1:0] m_mid, input bit noisy);
        int guard;
        guard = 0;
        while (!model_done() && guard < 200) begin
            if (noisy) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, m_mid);
            else       cyc(1'b0, 1'b0, 1'b0, m_mid);
            guard++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        cyc_no++;
        if (q.size() > 0) begin
            e = q.pop_front();
            g.li  = ifc.load_init;
            g.en  = ifc.enab_iter;
            g.idx = ifc.iter_idx;
            g.lr  = ifc.load_result;
            g.rdy = ifc.ready_cordic;
            g.bsy = ifc.busy;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs cyc%0d: got li=%b en=%b idx=%0d lr=%b rdy=%b busy=%b required li=%b en=%b idx=%0d lr=%b rdy=%b busy=%b",
                         cyc_no, g.li, g.en, g.idx, g.lr, g.rdy, g.bsy,
                         e.li, e.en, e.idx, e.lr, e.rdy, e.bsy);
            end
        end
    end

    initial begin
        int guard;
        ifc.beg_cordic = 1'b0;
        ifc.ack_cordic = 1'b0;
        ifc.iter_max   = '0;
        reset          = 1'b1;

        // Reset, with start/ack asserted to confirm reset dominates.
        cyc(1'b1, 1'b1, 1'b1, 4'd15);
        cyc(1'b1, 1'b1, 1'b1, 4'd15);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 1'b0, 4'd5);

        // Nominal 16-iteration run, ack withheld 10 cycles in DONE.
        cyc(1'b1, 1'b0, 1'b0, 4'd15);
        run_to_done(4'd9, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0, 4'd2);
        cyc(1'b0, 1'b1, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);

        // Minimum run.
        cyc(1'b1, 1'b0, 1'b0, 4'd0);
        run_to_done(4'd7, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0);

        // Spurious beg/ack and iter_max=3 while running.
        cyc(1'b1, 1'b0, 1'b0, 4'd15);
        cyc(1'b1, 1'b1, 1'b0, 4'd3);
        run_to_done(4'd3, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 4'd3);

        // Reset while iter_idx is 7, then a full fresh run.
        cyc(1'b1, 1'b0, 1'b0, 4'd15);
        guard = 0;
        while (!(m_act && m_t == 9) && guard < 50) begin
            cyc(1'b0, 1'b0, 1'b0, 4'd15);
            guard++;
        end
        cyc(1'b0, 1'b0, 1'b1, 4'd15);
        cyc(1'b0, 1'b0, 1'b0, 4'd15);
        cyc(1'b1, 1'b0, 1'b0, 4'd15);
        run_to_done(4'd1, 1'b0);

        // Simultaneous beg+ack in DONE, then a normal start.
        cyc(1'b1, 1'b1, 1'b0, 4'd2);
        cyc(1'b1, 1'b0, 1'b0, 4'd2);
        run_to_done(4'd0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 4'd0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 63) == 0),
                4'($urandom_range(0, 15)));
        end

        cyc(1'b0, 1'b0, 1'b1, 4'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
